// File: rtl/dfr_axi_lite_master.sv
// AXI4-Lite initiator: single-beat valid/ready commands to AXI4-Lite transactions, one outstanding.
// Optional poll-read feature compiled in with `define DFR_AXIM_POLL_EN.
module dfr_axi_lite_master #(
  parameter int C_M_AXI_DATA_WIDTH = 32,
  parameter int C_M_AXI_ADDR_WIDTH = 16,
  parameter int POLL_LIMIT         = 1024
) (
  input  logic                              M_AXI_ACLK,
  input  logic                              M_AXI_ARESETN,
  input  logic                              cmd_valid,
  output logic                              cmd_ready,
  input  logic                              cmd_write,
  input  logic                              cmd_poll,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]     cmd_addr,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]     cmd_wdata,
  input  logic [C_M_AXI_DATA_WIDTH/8-1:0]   cmd_wstrb,
  output logic                              rsp_valid,
  input  logic                              rsp_ready,
  output logic [C_M_AXI_DATA_WIDTH-1:0]     rsp_data,
  output logic [1:0]                        rsp_resp,
  output logic                              rsp_timeout,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_AWADDR,
  output logic                              M_AXI_AWVALID,
  input  logic                              M_AXI_AWREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_WDATA,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
  output logic                              M_AXI_WVALID,
  input  logic                              M_AXI_WREADY,
  input  logic [1:0]                        M_AXI_BRESP,
  input  logic                              M_AXI_BVALID,
  output logic                              M_AXI_BREADY,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_ARADDR,
  output logic                              M_AXI_ARVALID,
  input  logic                              M_AXI_ARREADY,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_RDATA,
  input  logic [1:0]                        M_AXI_RRESP,
  input  logic                              M_AXI_RVALID,
  output logic                              M_AXI_RREADY
);

  typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, RSP} state_t;

  state_t                            state_q, state_d;
  logic                              cmd_ready_d, rsp_valid_d;
  logic [C_M_AXI_DATA_WIDTH-1:0]     rsp_data_d, wdata_d;
  logic [1:0]                        rsp_resp_d;
  logic [C_M_AXI_ADDR_WIDTH-1:0]     awaddr_d, araddr_d;
  logic [C_M_AXI_DATA_WIDTH/8-1:0]   wstrb_d;
  logic                              awvalid_d, wvalid_d, bready_d, arvalid_d, rready_d;
  logic                              aw_done, aw_done_d, w_done, w_done_d;
  logic                              aw_fire, w_fire;

  assign aw_fire = M_AXI_AWVALID && M_AXI_AWREADY;
  assign w_fire  = M_AXI_WVALID && M_AXI_WREADY;

`ifdef DFR_AXIM_POLL_EN
  logic        poll_q, poll_d, timeout_d, poll_again, limit_hit;
  logic [15:0] poll_cnt, poll_cnt_d;
  logic [16:0] poll_inc;

  // The registered write data doubles as the poll mask.
  assign poll_inc   = {1'b0, poll_cnt} + 17'd1;
  assign limit_hit  = poll_inc >= 17'(POLL_LIMIT);
  assign poll_again = poll_q && ((M_AXI_RDATA & M_AXI_WDATA) != '0) && (M_AXI_RRESP == 2'b00);
`else
  logic unused_poll;
  assign unused_poll = cmd_poll ^ (POLL_LIMIT != 0);
  assign rsp_timeout = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    cmd_ready_d = cmd_ready;
    rsp_valid_d = rsp_valid;
    rsp_data_d  = rsp_data;
    rsp_resp_d  = rsp_resp;
    awaddr_d    = M_AXI_AWADDR;
    araddr_d    = M_AXI_ARADDR;
    wdata_d     = M_AXI_WDATA;
    wstrb_d     = M_AXI_WSTRB;
    awvalid_d   = M_AXI_AWVALID;
    wvalid_d    = M_AXI_WVALID;
    bready_d    = M_AXI_BREADY;
    arvalid_d   = M_AXI_ARVALID;
    rready_d    = M_AXI_RREADY;
    aw_done_d   = aw_done;
    w_done_d    = w_done;
`ifdef DFR_AXIM_POLL_EN
    poll_d      = poll_q;
    poll_cnt_d  = poll_cnt;
    timeout_d   = rsp_timeout;
`endif
    case (state_q)
      IDLE: begin
        cmd_ready_d = 1'b1;
        if (cmd_valid && cmd_ready) begin
          cmd_ready_d = 1'b0;
          awaddr_d    = cmd_addr;
          araddr_d    = cmd_addr;
          wdata_d     = cmd_wdata;
          wstrb_d     = cmd_wstrb;
`ifdef DFR_AXIM_POLL_EN
          poll_d      = cmd_poll && !cmd_write;
          poll_cnt_d  = '0;
`endif
          if (cmd_write) begin
            state_d   = WR_REQ;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            aw_done_d = 1'b0;
            w_done_d  = 1'b0;
          end else begin
            state_d   = RD_REQ;
            arvalid_d = 1'b1;
          end
        end
      end
      WR_REQ: begin
        if (aw_fire) begin
          awvalid_d = 1'b0;
          aw_done_d = 1'b1;
        end
        if (w_fire) begin
          wvalid_d = 1'b0;
          w_done_d = 1'b1;
        end
        if ((aw_done || aw_fire) && (w_done || w_fire)) begin
          state_d  = WR_RESP;
          bready_d = 1'b1;
        end
      end
      WR_RESP: begin
        if (M_AXI_BVALID && M_AXI_BREADY) begin
          bready_d    = 1'b0;
          rsp_resp_d  = M_AXI_BRESP;
          rsp_data_d  = '0;
          rsp_valid_d = 1'b1;
`ifdef DFR_AXIM_POLL_EN
          timeout_d   = 1'b0;
`endif
          state_d     = RSP;
        end
      end
      RD_REQ: begin
        if (M_AXI_ARVALID && M_AXI_ARREADY) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = RD_RESP;
        end
      end
      RD_RESP: begin
        if (M_AXI_RVALID && M_AXI_RREADY) begin
          rready_d   = 1'b0;
          rsp_data_d = M_AXI_RDATA;
          rsp_resp_d = M_AXI_RRESP;
`ifdef DFR_AXIM_POLL_EN
          poll_cnt_d = poll_inc[15:0];
          if (poll_again && !limit_hit) begin
            arvalid_d = 1'b1;
            state_d   = RD_REQ;
          end else begin
            // A poll still unsatisfied at this point has used up its read budget.
            timeout_d   = poll_again;
            rsp_valid_d = 1'b1;
            state_d     = RSP;
          end
`else
          rsp_valid_d = 1'b1;
          state_d     = RSP;
`endif
        end
      end
      RSP: begin
        if (rsp_valid && rsp_ready) begin
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) begin
      state_q       <= IDLE;
      cmd_ready     <= 1'b0;
      rsp_valid     <= 1'b0;
      rsp_data      <= '0;
      rsp_resp      <= '0;
      M_AXI_AWADDR  <= '0;
      M_AXI_ARADDR  <= '0;
      M_AXI_WDATA   <= '0;
      M_AXI_WSTRB   <= '0;
      M_AXI_AWVALID <= 1'b0;
      M_AXI_WVALID  <= 1'b0;
      M_AXI_BREADY  <= 1'b0;
      M_AXI_ARVALID <= 1'b0;
      M_AXI_RREADY  <= 1'b0;
      aw_done       <= 1'b0;
      w_done        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cmd_ready     <= cmd_ready_d;
      rsp_valid     <= rsp_valid_d;
      rsp_data      <= rsp_data_d;
      rsp_resp      <= rsp_resp_d;
      M_AXI_AWADDR  <= awaddr_d;
      M_AXI_ARADDR  <= araddr_d;
      M_AXI_WDATA   <= wdata_d;
      M_AXI_WSTRB   <= wstrb_d;
      M_AXI_AWVALID <= awvalid_d;
      M_AXI_WVALID  <= wvalid_d;
      M_AXI_BREADY  <= bready_d;
      M_AXI_ARVALID <= arvalid_d;
      M_AXI_RREADY  <= rready_d;
      aw_done       <= aw_done_d;
      w_done        <= w_done_d;
    end
  end

`ifdef DFR_AXIM_POLL_EN
  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) begin
      poll_q      <= 1'b0;
      poll_cnt    <= '0;
      rsp_timeout <= 1'b0;
    end else begin
      poll_q      <= poll_d;
      poll_cnt    <= poll_cnt_d;
      rsp_timeout <= timeout_d;
    end
  end
`endif

endmodule
